// File: rtl/cpc_fec_encoder.sv
// Streaming cross-parity-check FEC encoder: gathers DEPTH rows of WIDTH bits,
// builds even row/column/total parity on the fly and hands off the whole block.
module cpc_fec_encoder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DEPTH-1:0][WIDTH-1:0] out_data,
    output logic [DEPTH-1:0]            out_row_parity,
    output logic [WIDTH-1:0]            out_col_parity,
    output logic                        out_total_parity,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [15:0]                 out_block_cnt
);

    localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(DEPTH - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] row_cnt;

    // Handshake flags decode straight from the state flop, never from inputs.
    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == OUTPUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= COLLECT;
            row_cnt          <= '0;
            out_data         <= '0;
            out_row_parity   <= '0;
            out_col_parity   <= '0;
            out_total_parity <= 1'b0;
            out_block_cnt    <= '0;
        end else if (clear) begin
            state            <= COLLECT;
            row_cnt          <= '0;
            out_data         <= '0;
            out_row_parity   <= '0;
            out_col_parity   <= '0;
            out_total_parity <= 1'b0;
        end else if (state == OUTPUT) begin
            if (out_ready) begin
                state            <= COLLECT;
                out_data         <= '0;
                out_row_parity   <= '0;
                out_col_parity   <= '0;
                out_total_parity <= 1'b0;
                out_block_cnt    <= out_block_cnt + 16'd1;
            end
        end else if (in_valid) begin
            out_data[row_cnt]       <= in_data;
            out_row_parity[row_cnt] <= ^in_data;
            out_col_parity          <= out_col_parity ^ in_data;
            out_total_parity        <= out_total_parity ^ (^in_data);
            // Explicit wrap so non-power-of-two depths work.
            if (row_cnt == LAST_ROW) begin
                row_cnt <= '0;
                state   <= OUTPUT;
            end else begin
                row_cnt <= row_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpc_fec_encoder.sv
// Scoreboard bench for cpc_fec_encoder: a block-level reference model queues
// expected blocks; an independent monitor compares whatever the DUT presents.
module tb_cpc_fec_encoder;

    localparam int unsigned W = 4;
    localparam int unsigned D = 4;

    typedef struct packed {
        logic [D-1:0][W-1:0] data;
        logic [D-1:0]        rp;
        logic [W-1:0]        cp;
        logic                tp;
    } blk_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                clear = 1'b0;
    logic [W-1:0]        in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [D-1:0][W-1:0] out_data;
    logic [D-1:0]        out_row_parity;
    logic [W-1:0]        out_col_parity;
    logic                out_total_parity;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [15:0]         out_block_cnt;

    int n_cmp = 0;
    int n_err = 0;

    cpc_fec_encoder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear            (clear),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_row_parity   (out_row_parity),
        .out_col_parity   (out_col_parity),
        .out_total_parity (out_total_parity),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_block_cnt    (out_block_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (block level) ----------------
    logic [W-1:0] m_rows[$];
    blk_t         exp_q[$];
    bit           m_pending = 1'b0;
    int           m_blk = 0;

    function automatic blk_t build_block(input logic [W-1:0] rows[$]);
        blk_t b;
        int   ones;
        int   all_ones;
        b = '0;
        all_ones = 0;
        for (int r = 0; r < int'(D); r++) begin
            b.data[r] = rows[r];
            ones = 0;
            for (int c = 0; c < int'(W); c++) ones += int'(rows[r][c]);
            b.rp[r] = (ones % 2) == 1;
            all_ones += ones;
        end
        for (int c = 0; c < int'(W); c++) begin
            ones = 0;
            for (int r = 0; r < int'(D); r++) ones += int'(rows[r][c]);
            b.cp[c] = (ones % 2) == 1;
        end
        b.tp = (all_ones % 2) == 1;
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rows.delete();
            exp_q.delete();
            m_pending = 1'b0;
            m_blk = 0;
        end else if (clear) begin
            m_rows.delete();
            exp_q.delete();
            m_pending = 1'b0;
        end else if (m_pending) begin
            if (out_ready) begin
                void'(exp_q.pop_front());
                m_pending = 1'b0;
                m_blk = (m_blk + 1) % 65536;
            end
        end else if (in_valid) begin
            m_rows.push_back(in_data);
            if (m_rows.size() == int'(D)) begin
                exp_q.push_back(build_block(m_rows));
                m_rows.delete();
                m_pending = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    always begin
        @(posedge clk);
        #1;
        chk("in_ready", 64'(in_ready), 64'(!m_pending));
        chk("out_valid", 64'(out_valid), 64'(m_pending));
        chk("block_cnt", 64'(out_block_cnt), 64'(16'(m_blk)));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL block_unexpected: got out_valid=1 expected no block at %0t", $time);
            end else begin
                chk("out_data", 64'(out_data), 64'(exp_q[0].data));
                chk("row_parity", 64'(out_row_parity), 64'(exp_q[0].rp));
                chk("col_parity", 64'(out_col_parity), 64'(exp_q[0].cp));
                chk("total_parity", 64'(out_total_parity), 64'(exp_q[0].tp));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy, input logic clr);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_rp"}, 64'(out_row_parity), 64'd0);
        chk({tag, "_cp"}, 64'(out_col_parity), 64'd0);
        chk({tag, "_tp"}, 64'(out_total_parity), 64'd0);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_cnt"}, 64'(out_block_cnt), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    logic [D-1:0][W-1:0] rx;
    logic [D-1:0]        rs;
    logic [W-1:0]        cs;
    int                  er;
    int                  ec;

    // Minimal receive-side check: syndrome, locate and fix a single-bit error.
    task automatic loopback(input bit flip, input logic [15:0] orig);
        rx = out_data;
        if (flip) rx[2][1] = ~rx[2][1];
        er = -1;
        ec = -1;
        for (int r = 0; r < int'(D); r++) begin
            rs[r] = (^rx[r]) ^ out_row_parity[r];
            if (rs[r]) er = r;
        end
        for (int c = 0; c < int'(W); c++) begin
            cs[c] = out_col_parity[c];
            for (int r = 0; r < int'(D); r++) cs[c] = cs[c] ^ rx[r][c];
            if (cs[c]) ec = c;
        end
        chk(flip ? "lb_detect_flip" : "lb_detect_clean", 64'(|{rs, cs}), 64'(flip));
        if (flip && $countones(rs) == 1 && $countones(cs) == 1) rx[er][ec] = ~rx[er][ec];
        chk("lb_corrected", 64'(rx), 64'(orig));
    endtask

    initial begin
        // reset state
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: back-to-back block, out_ready high
        cyc(1, 4'b0111, 1, 0);
        cyc(1, 4'b1111, 1, 0);
        cyc(1, 4'b1111, 1, 0);
        cyc(1, 4'b1110, 0, 0);
        cyc(0, 4'b0000, 0, 0);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_rp", 64'(out_row_parity), 64'(4'b1001));
        chk("t1_cp", 64'(out_col_parity), 64'(4'b1001));
        chk("t1_tp", 64'(out_total_parity), 64'd0);
        loopback(1'b1, 16'hEFF7);
        loopback(1'b0, 16'hEFF7);
        cyc(0, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 1, 0);
        chk("t1_cnt", 64'(out_block_cnt), 64'd1);

        // 2: hold with out_ready low, concurrent in_valid must not be consumed
        cyc(1, 4'b0111, 0, 0);
        cyc(1, 4'b1111, 0, 0);
        cyc(1, 4'b1111, 0, 0);
        cyc(1, 4'b1110, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 4'b1010, 0, 0);
        chk("t2_in_ready", 64'(in_ready), 64'd0);
        cyc(0, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 0, 0);
        chk("t2_cnt", 64'(out_block_cnt), 64'd2);

        // 3: rows with gaps 0,3,1
        cyc(1, 4'b0001, 0, 0);
        cyc(1, 4'b0010, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 4'b1111, 0, 0);
        cyc(1, 4'b0100, 0, 0);
        cyc(0, 4'b1111, 0, 0);
        cyc(1, 4'b1000, 0, 0);
        cyc(0, 4'b0000, 1, 0);
        chk("t3_rp", 64'(out_row_parity), 64'(4'b1111));
        chk("t3_cp", 64'(out_col_parity), 64'(4'b1111));
        chk("t3_data", 64'(out_data), 64'h8421);

        // 4: clear discards partial block; clear during output drops it
        cyc(1, 4'b0011, 0, 0);
        cyc(1, 4'b0110, 0, 0);
        cyc(1, 4'b1001, 0, 1);
        cyc(1, 4'b1111, 0, 0);
        cyc(1, 4'b0000, 0, 0);
        cyc(1, 4'b1010, 0, 0);
        cyc(1, 4'b0101, 0, 0);
        cyc(0, 4'b0000, 0, 0);
        chk("t4_rp", 64'(out_row_parity), 64'd0);
        chk("t4_cp", 64'(out_col_parity), 64'd0);
        chk("t4_data", 64'(out_data), 64'h5A0F);
        cyc(0, 4'b0000, 1, 1);
        cyc(0, 4'b0000, 1, 0);
        chk("t4_clr_valid", 64'(out_valid), 64'd0);
        chk("t4_clr_cnt", 64'(out_block_cnt), 64'd3);

        // 5: async reset mid-block, then a clean block
        cyc(1, 4'b1100, 1, 0);
        cyc(1, 4'b0110, 1, 0);
        cyc(1, 4'b0011, 1, 0);
        cyc(0, 4'b0000, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 4'b1000, 0, 0);
        cyc(1, 4'b1100, 0, 0);
        cyc(1, 4'b1110, 0, 0);
        cyc(1, 4'b1111, 0, 0);
        cyc(0, 4'b0000, 1, 0);
        chk("t5_rp", 64'(out_row_parity), 64'(4'b0101));
        chk("t5_cp", 64'(out_col_parity), 64'(4'b0101));
        chk("t5_tp", 64'(out_total_parity), 64'd0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 9) < 6,
                $urandom_range(0, 99) < 3);
        for (int i = 0; i < 4; i++) cyc(0, 4'b0000, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
